// File: rtl/dvi_pkg.sv
// Shared raster geometry, colour widths and adapter types for the DVI output path.
// H_ACTIVE/V_ACTIVE hold the current build's active area (4x2 bring-up raster).
package dvi_pkg;
  localparam int H_ACTIVE = 4;
  localparam int V_ACTIVE = 2;
  localparam int COLOR_W  = 8;
  localparam int X_POS_W  = 11;
  localparam int Y_POS_W  = 10;

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } adapt_state_e;

  typedef struct packed {
    logic               sof;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } pix_t;

  localparam int PIX_W = $bits(pix_t);
endpackage

// File: rtl/pixel_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// A write into an empty FIFO becomes visible on dout_o one cycle later.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 25
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // Flags are registered, so a push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/pixel_stream_adapter.sv
// Buffers an upstream pixel stream and locks it to the DVI raster on the sof pixel.
// Colour out is registered one cycle after x/y; s_ready_o drops while the FIFO is full.
module pixel_stream_adapter
  import dvi_pkg::*;
#(
  parameter int                       FIFO_DEPTH = 16,
  parameter logic [3*COLOR_W-1:0]     FILL_COLOR = 24'h000000
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic               s_sof_i,
  input  logic [COLOR_W-1:0] s_red_i,
  input  logic [COLOR_W-1:0] s_green_i,
  input  logic [COLOR_W-1:0] s_blue_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               locked_o,
  output logic               err_underflow_o,
  output logic               err_align_o
);
  pix_t                 push_dat, head;
  logic                 fifo_full, fifo_empty, pop;
  logic                 visible, origin, sof_ok;
  adapt_state_e         state_q;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 locked_q, err_uf_q, err_al_q;

  assign push_dat = '{sof: s_sof_i, red: s_red_i, green: s_green_i, blue: s_blue_i};

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (s_valid_i && s_ready_o),
    .din_i   (push_dat),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_ready_o = !fifo_full;
  assign visible   = (x_i < X_POS_W'(H_ACTIVE)) && (y_i < Y_POS_W'(V_ACTIVE));
  assign origin    = (x_i == '0) && (y_i == '0);
  // While running, only the origin pixel may carry sof.
  assign sof_ok    = (head.sof == origin);

  assign pop = !fifo_empty &&
               (((state_q == ST_SEEK)  && !head.sof) ||
                ((state_q == ST_ARMED) && origin) ||
                ((state_q == ST_RUN)   && visible && sof_ok));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_SEEK;
      rgb_q    <= '0;
      locked_q <= 1'b0;
      err_uf_q <= 1'b0;
      err_al_q <= 1'b0;
    end else begin
      rgb_q    <= '0;
      err_uf_q <= 1'b0;
      err_al_q <= 1'b0;
      locked_q <= (state_q == ST_RUN);
      case (state_q)
        ST_SEEK: begin
          if (visible) rgb_q <= FILL_COLOR;
          if (!fifo_empty && head.sof) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (origin) begin
            rgb_q    <= {head.red, head.green, head.blue};
            locked_q <= 1'b1;
            state_q  <= ST_RUN;
          end else if (visible) begin
            rgb_q <= FILL_COLOR;
          end
        end
        ST_RUN: begin
          if (visible) begin
            if (fifo_empty) begin
              rgb_q    <= FILL_COLOR;
              err_uf_q <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= ST_SEEK;
            end else if (!sof_ok) begin
              rgb_q    <= FILL_COLOR;
              err_al_q <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= ST_SEEK;
            end else begin
              rgb_q <= {head.red, head.green, head.blue};
            end
          end
        end
        default: begin
          locked_q <= 1'b0;
          state_q  <= ST_SEEK;
        end
      endcase
    end
  end

  assign red_o           = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign green_o         = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue_o          = rgb_q[COLOR_W-1   -: COLOR_W];
  assign locked_o        = locked_q;
  assign err_underflow_o = err_uf_q;
  assign err_align_o     = err_al_q;
endmodule

// File: tb/tb_pixel_stream_adapter.sv
// Directed bench for pixel_stream_adapter on a 6x3 raster with a 4x2 active area.
module tb_pixel_stream_adapter;
  import dvi_pkg::*;

  localparam logic [23:0] FILL = 24'hABCDEF;
  localparam int H_TOT = 6;
  localparam int NPOS  = 18;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b1;
  logic               s_valid_i = 1'b0;
  logic               s_ready_o;
  logic               s_sof_i = 1'b0;
  logic [COLOR_W-1:0] s_red_i = '0, s_green_i = '0, s_blue_i = '0;
  logic [X_POS_W-1:0] x_i = X_POS_W'(5);
  logic [Y_POS_W-1:0] y_i = Y_POS_W'(2);
  logic [COLOR_W-1:0] red_o, green_o, blue_o;
  logic               locked_o, err_underflow_o, err_align_o;

  int checks = 0;
  int errors = 0;
  logic [23:0] obs_rgb [NPOS];
  logic        obs_lock[NPOS];
  logic        obs_uf  [NPOS];
  logic        obs_al  [NPOS];

  pixel_stream_adapter #(.FIFO_DEPTH(16), .FILL_COLOR(FILL)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_sof_i(s_sof_i),
    .s_red_i(s_red_i), .s_green_i(s_green_i), .s_blue_i(s_blue_i),
    .x_i(x_i), .y_i(y_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .locked_o(locked_o), .err_underflow_o(err_underflow_o), .err_align_o(err_align_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [23:0] pix(input int k);
    logic [7:0] r, g, b;
    r = 8'(k * 3 + 1);
    g = 8'(k * 5 + 2);
    b = 8'(k * 7 + 3);
    return {r, g, b};
  endfunction

  function automatic logic pos_vis(input int p);
    return ((p % H_TOT) < H_ACTIVE) && ((p / H_TOT) < V_ACTIVE);
  endfunction

  function automatic int pos_k(input int p);
    return (p / H_TOT) * H_ACTIVE + (p % H_TOT);
  endfunction

  task automatic drive_xy(input int x, input int y);
    x_i = X_POS_W'(x);
    y_i = Y_POS_W'(y);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_xy(5, 2);
  endtask

  task automatic push(input int k, input logic sof);
    s_valid_i = 1'b1;
    s_sof_i   = sof;
    {s_red_i, s_green_i, s_blue_i} = pix(k);
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic push_frame(input int base, input int n);
    for (int i = 0; i < n; i++) push(base + i, i == 0);
  endtask

  task automatic capture(input int p0);
    for (int p = p0; p < NPOS; p++) begin
      drive_xy(p % H_TOT, p / H_TOT);
      obs_rgb[p]  = {red_o, green_o, blue_o};
      obs_lock[p] = locked_o;
      obs_uf[p]   = err_underflow_o;
      obs_al[p]   = err_align_o;
    end
  endtask

  task automatic do_reset();
    s_valid_i = 1'b0;
    x_i = X_POS_W'(5);
    y_i = Y_POS_W'(2);
    #2 rst_n_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Compares one captured frame: pixels from index `base` locked, no errors.
  task automatic expect_clean_frame(input string tag, input int base, input int p0);
    for (int p = p0; p < NPOS; p++) begin
      logic [23:0] exp_rgb;
      exp_rgb = pos_vis(p) ? pix(base + pos_k(p)) : 24'h0;
      checks++;
      if (obs_rgb[p] !== exp_rgb) begin
        errors++;
        $display("FAIL %s_rgb p=%0d got %h want %h", tag, p, obs_rgb[p], exp_rgb);
      end
      checks++;
      if (obs_lock[p] !== 1'b1 || obs_uf[p] !== 1'b0 || obs_al[p] !== 1'b0) begin
        errors++;
        $display("FAIL %s_flags p=%0d got lock/uf/al %b%b%b want 100", tag, p, obs_lock[p], obs_uf[p], obs_al[p]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({red_o, green_o, blue_o} !== 24'h0 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got rgb %h lock %b want 000000 0", {red_o, green_o, blue_o}, locked_o);
    end
    checks++;
    if (s_ready_o !== 1'b1 || err_underflow_o !== 1'b0 || err_align_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy/uf/al %b%b%b want 100", s_ready_o, err_underflow_o, err_align_o);
    end
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_frame();
    do_reset();
    push_frame(0, 8);
    idle(2);
    capture(0);
    expect_clean_frame("frame", 0, 0);
  endtask

  task automatic test_junk();
    do_reset();
    for (int i = 0; i < 3; i++) push(50 + i, 1'b0);
    push_frame(0, 8);
    idle(3);
    capture(0);
    expect_clean_frame("junk", 0, 0);
  endtask

  task automatic test_underflow();
    do_reset();
    push_frame(0, 5);
    idle(2);
    capture(0);
    for (int p = 0; p < NPOS; p++) begin
      logic [23:0] exp_rgb;
      logic        exp_uf;
      exp_rgb = !pos_vis(p) ? 24'h0 : (pos_k(p) < 5 ? pix(pos_k(p)) : FILL);
      exp_uf  = pos_vis(p) && pos_k(p) == 5;
      checks++;
      if (obs_rgb[p] !== exp_rgb) begin
        errors++;
        $display("FAIL uf_rgb p=%0d got %h want %h", p, obs_rgb[p], exp_rgb);
      end
      checks++;
      if (obs_uf[p] !== exp_uf || obs_lock[p] !== (p < 7) || obs_al[p] !== 1'b0) begin
        errors++;
        $display("FAIL uf_flags p=%0d got lock/uf/al %b%b%b want %b%b0", p, obs_lock[p], obs_uf[p], obs_al[p], p < 7, exp_uf);
      end
    end
    push_frame(10, 8);
    idle(2);
    capture(0);
    expect_clean_frame("uf_relock", 10, 0);
  endtask

  task automatic test_align();
    do_reset();
    for (int i = 0; i < 11; i++) push(i, (i == 0) || (i == 3));
    idle(2);
    capture(0);
    for (int p = 0; p < NPOS; p++) begin
      logic [23:0] exp_rgb;
      logic        exp_al;
      exp_rgb = !pos_vis(p) ? 24'h0 : (pos_k(p) < 3 ? pix(pos_k(p)) : FILL);
      exp_al  = pos_vis(p) && pos_k(p) == 3;
      checks++;
      if (obs_rgb[p] !== exp_rgb) begin
        errors++;
        $display("FAIL al_rgb p=%0d got %h want %h", p, obs_rgb[p], exp_rgb);
      end
      checks++;
      if (obs_al[p] !== exp_al || obs_lock[p] !== (p < 3) || obs_uf[p] !== 1'b0) begin
        errors++;
        $display("FAIL al_flags p=%0d got lock/uf/al %b%b%b want %b0%b", p, obs_lock[p], obs_uf[p], obs_al[p], p < 3, exp_al);
      end
    end
    capture(0);
    expect_clean_frame("al_relock", 3, 0);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (s_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL full_fill_rdy i=%0d got %b want 1", i, s_ready_o);
      end
      push(i, (i == 0) || (i == 8));
    end
    s_valid_i = 1'b1;
    s_sof_i   = 1'b1;
    {s_red_i, s_green_i, s_blue_i} = pix(16);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL full_rdy i=%0d got %b want 0", i, s_ready_o);
      end
      if (i < 2) drive_xy(5, 2);
    end
    drive_xy(0, 0);
    checks++;
    if (s_ready_o !== 1'b1 || {red_o, green_o, blue_o} !== pix(0) || locked_o !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got rdy %b rgb %h lock %b want 1 %h 1", s_ready_o, {red_o, green_o, blue_o}, locked_o, pix(0));
    end
    drive_xy(1, 0);
    s_valid_i = 1'b0;
    checks++;
    if ({red_o, green_o, blue_o} !== pix(1)) begin
      errors++;
      $display("FAIL full_px1 got %h want %h", {red_o, green_o, blue_o}, pix(1));
    end
    capture(2);
    expect_clean_frame("full_f1", 0, 2);
    capture(0);
    expect_clean_frame("full_f2", 8, 0);
    for (int i = 17; i < 24; i++) push(i, 1'b0);
    capture(0);
    expect_clean_frame("full_f3", 16, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(0, 8);
    push_frame(8, 8);
    idle(2);
    drive_xy(0, 0);
    drive_xy(1, 0);
    drive_xy(2, 0);
    checks++;
    if ({red_o, green_o, blue_o} !== pix(2)) begin
      errors++;
      $display("FAIL rmid_pre got %h want %h", {red_o, green_o, blue_o}, pix(2));
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({red_o, green_o, blue_o} !== 24'h0 || locked_o !== 1'b0 || s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async got rgb %h lock %b rdy %b want 000000 0 1", {red_o, green_o, blue_o}, locked_o, s_ready_o);
    end
    @(posedge clk_i);
    #1;
    x_i = X_POS_W'(5);
    y_i = Y_POS_W'(2);
    rst_n_i = 1'b1;
    capture(0);
    for (int p = 0; p < NPOS; p++) begin
      logic [23:0] exp_rgb;
      exp_rgb = pos_vis(p) ? FILL : 24'h0;
      checks++;
      if (obs_rgb[p] !== exp_rgb || obs_lock[p] !== 1'b0 || obs_uf[p] !== 1'b0 || obs_al[p] !== 1'b0) begin
        errors++;
        $display("FAIL rmid_empty p=%0d got rgb %h lock/uf/al %b%b%b want %h 000", p, obs_rgb[p], obs_lock[p], obs_uf[p], obs_al[p], exp_rgb);
      end
    end
    push_frame(40, 8);
    idle(2);
    capture(0);
    expect_clean_frame("rmid_relock", 40, 0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_junk();
    test_underflow();
    test_align();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_stream_adapter.md
PIXEL_STREAM_ADAPTER -- requirements
Module: pixel_stream_adapter

Interface
REQ-001 Parameters SHALL be FIFO_DEPTH, default 16, meaning pixel FIFO entries (power of two, >=4).
REQ-002 Parameters SHALL include FILL_COLOR, default 24'h000000, meaning {R,G,B} shown for visible pixels when not locked or on underflow.
REQ-003 Ports SHALL be, clock and reset first:
- clk_i  in  1  pixel clock, the only clock
- rst_n_i  in  1  reset, asynchronous, active-low
- s_valid_i  in  1  upstream pixel valid
- s_ready_o  out  1  adapter can accept a pixel
- s_sof_i  in  1  pixel is first of a frame
- s_red_i / s_green_i / s_blue_i  in  COLOR_W each  pixel colour
- x_i  in  X_POS_W  current raster x from the DVI sync stage
- y_i  in  Y_POS_W  current raster y from the DVI sync stage
- red_o / green_o / blue_o  out  COLOR_W each  colour to the DVI encoders
- locked_o  out  1  adapter is aligned to the raster
- err_underflow_o  out  1  one-cycle pulse, FIFO empty at a visible pixel
- err_align_o  out  1  one-cycle pulse, SOF found mid-frame or missing at frame start

Function
REQ-004 A pixel SHALL be visible when x_i < H_ACTIVE and y_i < V_ACTIVE; raster origin is x_i=0, y_i=0.
REQ-005 The FIFO SHALL store {sof, R, G, B}, with a push when s_valid_i && s_ready_o.
REQ-006 s_ready_o SHALL be !full, where full is registered; no push occurs while full, even when a pop happens in the same cycle.
REQ-007 Colour outputs SHALL be registered with exactly 1 cycle latency from x_i/y_i, matching the DVI stage's 1-cycle sync delay.
REQ-008 For a non-visible pixel, the outputs SHALL be 0, and no pop occurs.
REQ-009 The FSM SHALL have the states SEEK, ARMED and RUN.
REQ-010 In SEEK:
- if the FIFO is non-empty and the head sof is 0, pop one entry per cycle;
- if the head sof is 1, go to ARMED without popping.
REQ-011 In ARMED, hold the head until the raster origin; at the origin, pop the head, output its colour and go to RUN.
REQ-012 In SEEK or ARMED, visible pixels SHALL output FILL_COLOR.
REQ-013 In RUN, each visible pixel SHALL pop one entry and output its colour, with these checks:
- at the origin, the head must have sof=1;
- elsewhere, the head must have sof=0.
REQ-014 In RUN, a sof violation SHALL output FILL_COLOR, pulse err_align_o, skip the pop and go to SEEK.
REQ-015 In RUN, an empty FIFO at a visible pixel SHALL output FILL_COLOR, pulse err_underflow_o and go to SEEK.
REQ-016 A simultaneous push and pop SHALL keep the occupancy unchanged; a push into an empty FIFO SHALL NOT be poppable in the same cycle.
REQ-017 locked_o SHALL be registered and high exactly while the state is RUN.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use log2(FIFO_DEPTH)+1 bits.

Reset
REQ-019 On rst_n_i low, asynchronously: state SEEK, FIFO empty, outputs 0, s_ready_o 1, locked_o 0, error pulses 0.
REQ-020 Reset mid-frame SHALL discard all buffered pixels; after release, alignment restarts from SEEK.

Structure
REQ-021 H_ACTIVE, V_ACTIVE, COLOR_W, X_POS_W, Y_POS_W and the FSM state enum typedef SHALL live in dvi_pkg.
REQ-022 The FIFO SHALL be one sub-module, pixel_fifo: single clock, first-word-fall-through, with full/empty flags.

Verification
REQ-023 Reset, then a 4x2 frame (H_ACTIVE=4, V_ACTIVE=2 test config) streamed with sof on the first pixel: locked_o rises at the origin, and outputs reproduce pixels 0..7 one cycle after each x/y.
REQ-024 Three junk pixels (sof=0) precede the sof pixel: the junk is dropped in SEEK, no error fires, and the frame displays correctly.
REQ-025 Upstream stalls after 5 of 8 pixels: err_underflow_o pulses once at pixel 5, the remaining visible pixels show FILL_COLOR, and the state goes to SEEK, then relocks on the next frame.
REQ-026 sof is asserted on pixel 3 of a frame: err_align_o pulses at pixel 3, locked_o falls, and the adapter relocks at the next origin.
REQ-027 With the FIFO full (16 entries), s_ready_o=0; when a pop occurs, s_ready_o returns to 1 the next cycle, and no pixel is lost or duplicated.
REQ-028 rst_n_i is pulsed low mid-frame: outputs go to 0 immediately, the FIFO reads empty, and alignment restarts at the following sof and origin.
